// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the EX-stage hazard scheduler.
//   FWD_*   : ALU operand source selects (RF / MEM result / WB result).
//   state_e : FP occupancy FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_FP_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_scheduler_forward_unit.sv
// forward_unit: combinational operand-forwarding select for one EX source reg.
//   src_reg_i            : source register read by the instruction in EX
//   wr_reg_m_i/wr_en_m_i : MEM-stage destination / write enable
//   wr_reg_w_i/wr_en_w_i : WB-stage destination / write enable
//   sel_o                : FWD_MEM, FWD_WB or FWD_RF (MEM is the younger result, so it wins)
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_WIDTH = 4
) (
  input  logic [REG_WIDTH-1:0] src_reg_i,
  input  logic [REG_WIDTH-1:0] wr_reg_m_i,
  input  logic                 wr_en_m_i,
  input  logic [REG_WIDTH-1:0] wr_reg_w_i,
  input  logic                 wr_en_w_i,
  output logic [1:0]           sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (wr_en_m_i && (wr_reg_m_i == src_reg_i))      sel_o = FWD_MEM;
    else if (wr_en_w_i && (wr_reg_w_i == src_reg_i)) sel_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: pipeline hazard controller around the EX stage.
//   Inputs : ID/EX/MEM/WB register indices and control bits, taken-branch in MEM.
//   Outputs: alu_src1_o/alu_src2_o forwarding selects, stall_* holds,
//            flush_* bubbles, fp_busy_o, saturating stall/flush event counters.
//   Priority: rst > branch flush > FP occupancy stall > load-use stall.
//   FP_LAT must lie in 2..16 so FP_LAT-2 fits the 4-bit occupancy counter.
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int REG_WIDTH = 4,
  parameter int FP_LAT    = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_WIDTH-1:0] rsD_i,
  input  logic [REG_WIDTH-1:0] rtD_i,
  input  logic [REG_WIDTH-1:0] rsE_i,
  input  logic [REG_WIDTH-1:0] rtE_i,
  input  logic [REG_WIDTH-1:0] WriteRegE_i,
  input  logic                 RegWriteE_i,
  input  logic                 MemReadE_i,
  input  logic                 FloatingE_i,
  input  logic [REG_WIDTH-1:0] WriteRegM_i,
  input  logic                 RegWriteM_i,
  input  logic [REG_WIDTH-1:0] WriteRegW_i,
  input  logic                 RegWriteW_i,
  input  logic                 BranchTakenM_i,
  output logic [1:0]           alu_src1_o,
  output logic [1:0]           alu_src2_o,
  output logic                 stall_PC_o,
  output logic                 stall_IF_ID_o,
  output logic                 stall_ID_EX_o,
  output logic                 stall_EX_MEM_o,
  output logic                 flush_IF_ID_o,
  output logic                 flush_ID_EX_o,
  output logic                 flush_EX_MEM_o,
  output logic                 fp_busy_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  // Cycle 1 of an FP op is spent in IDLE, the last one is the release cycle,
  // so the counter covers the FP_LAT-2 cycles in between.
  localparam logic [3:0] FP_CNT_INIT = 4'(FP_LAT - 2);

  state_e               state_q, state_d;
  logic [3:0]           fp_cnt_q, fp_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic [1:0] sel1, sel2;
  logic       load_use, fp_stall, lu_stall, br_flush;

  forward_unit #(.REG_WIDTH(REG_WIDTH)) u_fwd_src1 (
    .src_reg_i (rsE_i),
    .wr_reg_m_i(WriteRegM_i),
    .wr_en_m_i (RegWriteM_i),
    .wr_reg_w_i(WriteRegW_i),
    .wr_en_w_i (RegWriteW_i),
    .sel_o     (sel1)
  );

  forward_unit #(.REG_WIDTH(REG_WIDTH)) u_fwd_src2 (
    .src_reg_i (rtE_i),
    .wr_reg_m_i(WriteRegM_i),
    .wr_en_m_i (RegWriteM_i),
    .wr_reg_w_i(WriteRegW_i),
    .wr_en_w_i (RegWriteW_i),
    .sel_o     (sel2)
  );

  assign load_use = MemReadE_i && RegWriteE_i &&
                    ((WriteRegE_i == rsD_i) || (WriteRegE_i == rtD_i));

  // FSM next state and hazard classification.
  always_comb begin
    state_d  = state_q;
    fp_cnt_d = fp_cnt_q;
    fp_stall = 1'b0;
    lu_stall = 1'b0;
    br_flush = 1'b0;
    if (BranchTakenM_i) begin
      // The FP op (if any) is younger than the branch and gets squashed.
      br_flush = 1'b1;
      state_d  = ST_IDLE;
      fp_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (FloatingE_i) begin
            fp_stall = 1'b1;
            fp_cnt_d = FP_CNT_INIT;
            state_d  = ST_FP_BUSY;
          end else if (load_use) begin
            lu_stall = 1'b1;
          end
        end
        ST_FP_BUSY: begin
          if (fp_cnt_q != 4'd0) begin
            fp_stall = 1'b1;
            fp_cnt_d = fp_cnt_q - 4'd1;
          end else begin
            // Release cycle: EX/MEM captures the FP result.
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs forced quiet while reset is held.
  always_comb begin
    alu_src1_o     = rst ? FWD_RF : sel1;
    alu_src2_o     = rst ? FWD_RF : sel2;
    stall_PC_o     = !rst && (fp_stall || lu_stall);
    stall_IF_ID_o  = !rst && (fp_stall || lu_stall);
    stall_ID_EX_o  = !rst && fp_stall;
    stall_EX_MEM_o = 1'b0;
    flush_IF_ID_o  = !rst && br_flush;
    flush_ID_EX_o  = !rst && (br_flush || lu_stall);
    flush_EX_MEM_o = !rst && (br_flush || fp_stall);
    fp_busy_o      = (state_q == ST_FP_BUSY);
    stall_cnt_o    = stall_cnt_q;
    flush_cnt_o    = flush_cnt_q;
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_PC_o && (stall_cnt_q != '1))     stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    if (BranchTakenM_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fp_cnt_q    <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fp_cnt_q    <= fp_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;

  typedef struct packed {
    logic [3:0] rsD, rtD, rsE, rtE, wrE;
    logic       rwE, mrE, fpE;
    logic [3:0] wrM;
    logic       rwM;
    logic [3:0] wrW;
    logic       rwW, br;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic [1:0] s1, s2;
    logic       st, sidex, fif, fid, fex, busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  in_t  in, in2;

  logic [1:0]  src1, src2, src1_2, src2_2;
  logic        stPC, stIF, stIDEX, stEXMEM, flIF, flID, flEX, busy;
  logic        stPC2, stIF2, stIDEX2, stEXMEM2, flIF2, flID2, flEX2, busy2;
  logic [15:0] scnt, fcnt;
  logic [1:0]  scnt2, fcnt2;

  int checks = 0;
  int errors = 0;
  int exp_sc = 0;
  int exp_fc = 0;
  vec_t tbl[12];

  always #5 clk = ~clk;

  hazard_scheduler #(.REG_WIDTH(4), .FP_LAT(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .rsD_i(in.rsD), .rtD_i(in.rtD), .rsE_i(in.rsE), .rtE_i(in.rtE),
    .WriteRegE_i(in.wrE), .RegWriteE_i(in.rwE), .MemReadE_i(in.mrE), .FloatingE_i(in.fpE),
    .WriteRegM_i(in.wrM), .RegWriteM_i(in.rwM), .WriteRegW_i(in.wrW), .RegWriteW_i(in.rwW),
    .BranchTakenM_i(in.br),
    .alu_src1_o(src1), .alu_src2_o(src2),
    .stall_PC_o(stPC), .stall_IF_ID_o(stIF), .stall_ID_EX_o(stIDEX), .stall_EX_MEM_o(stEXMEM),
    .flush_IF_ID_o(flIF), .flush_ID_EX_o(flID), .flush_EX_MEM_o(flEX),
    .fp_busy_o(busy), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  // Narrow counters and minimum FP latency for boundary checks.
  hazard_scheduler #(.REG_WIDTH(4), .FP_LAT(2), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .rsD_i(in2.rsD), .rtD_i(in2.rtD), .rsE_i(in2.rsE), .rtE_i(in2.rtE),
    .WriteRegE_i(in2.wrE), .RegWriteE_i(in2.rwE), .MemReadE_i(in2.mrE), .FloatingE_i(in2.fpE),
    .WriteRegM_i(in2.wrM), .RegWriteM_i(in2.rwM), .WriteRegW_i(in2.wrW), .RegWriteW_i(in2.rwW),
    .BranchTakenM_i(in2.br),
    .alu_src1_o(src1_2), .alu_src2_o(src2_2),
    .stall_PC_o(stPC2), .stall_IF_ID_o(stIF2), .stall_ID_EX_o(stIDEX2), .stall_EX_MEM_o(stEXMEM2),
    .flush_IF_ID_o(flIF2), .flush_ID_EX_o(flID2), .flush_EX_MEM_o(flEX2),
    .fp_busy_o(busy2), .stall_cnt_o(scnt2), .flush_cnt_o(fcnt2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compares every combinational output of dut for the current cycle and
  // advances the counter model using the expected stall and the driven branch.
  task automatic chk_outs(input string n, input logic [1:0] s1, input logic [1:0] s2,
                          input logic st, input logic sidex, input logic fif,
                          input logic fid, input logic fex, input logic bz);
    chk({n, ".src1"}, src1, s1);
    chk({n, ".src2"}, src2, s2);
    chk({n, ".stall_PC"}, stPC, st);
    chk({n, ".stall_IF_ID"}, stIF, st);
    chk({n, ".stall_ID_EX"}, stIDEX, sidex);
    chk({n, ".stall_EX_MEM"}, stEXMEM, 0);
    chk({n, ".flush_IF_ID"}, flIF, fif);
    chk({n, ".flush_ID_EX"}, flID, fid);
    chk({n, ".flush_EX_MEM"}, flEX, fex);
    chk({n, ".fp_busy"}, busy, bz);
    if (!rst) begin
      exp_sc += int'(st);
      exp_fc += int'(in.br);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnts(input string n);
    chk({n, ".stall_cnt"}, scnt, exp_sc);
    chk({n, ".flush_cnt"}, fcnt, exp_fc);
  endtask

  initial begin
    //                 rsD  rtD  rsE  rtE  wrE  rwE mrE fpE  wrM  rwM  wrW  rwW br    s1 s2 st sid fif fid fex bz
    tbl[0]  = '{'{4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 0, 0, 0, 4'd3, 1, 4'd3, 1, 0}, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{'{4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 0, 0, 0, 4'd3, 0, 4'd3, 1, 0}, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{'{4'd0, 4'd0, 4'd3, 4'd7, 4'd0, 0, 0, 0, 4'd7, 1, 4'd3, 1, 0}, 2'd2, 2'd1, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{'{4'd0, 4'd0, 4'd3, 4'd7, 4'd0, 0, 0, 0, 4'd3, 0, 4'd7, 0, 0}, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{'{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 4'd0, 1, 0}, 2'd1, 2'd1, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{'{4'd1, 4'd5, 4'd0, 4'd0, 4'd5, 1, 1, 0, 4'd9, 0, 4'd9, 0, 0}, 2'd0, 2'd0, 1, 0, 0, 1, 0, 0};
    tbl[6]  = '{'{4'd5, 4'd2, 4'd0, 4'd0, 4'd5, 1, 1, 0, 4'd9, 0, 4'd9, 0, 0}, 2'd0, 2'd0, 1, 0, 0, 1, 0, 0};
    tbl[7]  = '{'{4'd5, 4'd5, 4'd0, 4'd0, 4'd5, 0, 1, 0, 4'd9, 0, 4'd9, 0, 0}, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{'{4'd6, 4'd6, 4'd0, 4'd0, 4'd5, 1, 1, 0, 4'd9, 0, 4'd9, 0, 0}, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{'{4'd5, 4'd5, 4'd0, 4'd0, 4'd5, 1, 1, 0, 4'd9, 0, 4'd9, 0, 1}, 2'd0, 2'd0, 0, 0, 1, 1, 1, 0};
    tbl[10] = '{'{4'd0, 4'd0, 4'd2, 4'd4, 4'd0, 0, 0, 0, 4'd4, 1, 4'd2, 1, 1}, 2'd2, 2'd1, 0, 0, 1, 1, 1, 0};
    tbl[11] = '{'{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 1, 1, 0, 4'd15, 1, 4'd14, 1, 0}, 2'd1, 2'd1, 1, 0, 0, 1, 0, 0};

    // Reset with hazardous inputs: every output must stay quiet.
    rst = 1'b1;
    in  = '0;
    in2 = '0;
    in.rwM = 1'b1; in.br = 1'b1; in.fpE = 1'b1;
    #3;
    chk_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    tick; tick;
    chk_cnts("reset");
    in = '0;
    rst = 1'b0;

    // Branch kills an FP op mid-occupancy.
    in.fpE = 1'b1;
    #1 chk_outs("br_fp.c1", 0, 0, 1, 1, 0, 0, 1, 0);
    tick;
    in.br = 1'b1;
    #1 chk_outs("br_fp.c2", 0, 0, 0, 0, 1, 1, 1, 1);
    tick;
    in = '0;
    #1 chk_outs("br_fp.c3", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_fp.flush_cnt", fcnt, 1);
    chk_cnts("br_fp");
    tick;

    // Combinational vector table.
    for (int k = 0; k < 12; k++) begin
      in = tbl[k].i;
      #1 chk_outs($sformatf("vec%0d", k), tbl[k].s1, tbl[k].s2, tbl[k].st, tbl[k].sidex,
                  tbl[k].fif, tbl[k].fid, tbl[k].fex, tbl[k].busy);
      tick;
    end
    in = '0;
    chk_cnts("table");

    // Load-use then forwarding from MEM once the load advances.
    in.wrE = 4'd5; in.rwE = 1'b1; in.mrE = 1'b1; in.rtD = 4'd5;
    #1 chk_outs("lu.c1", 0, 0, 1, 0, 0, 1, 0, 0);
    tick;
    in = '0;
    in.wrM = 4'd5; in.rwM = 1'b1; in.rtE = 4'd5; in.rsE = 4'd1;
    #1 chk_outs("lu.c2", 0, 1, 0, 0, 0, 0, 0, 0);
    tick;
    in = '0;

    // FP op with FP_LAT=4: three stall cycles then release.
    in.fpE = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1 chk_outs($sformatf("fp.c%0d", c), 0, 0, 1, 1, 0, 0, 1, (c > 1));
      tick;
    end
    #1 chk_outs("fp.c4", 0, 0, 0, 0, 0, 0, 0, 1);
    tick;
    in.fpE = 1'b0;
    #1 chk_outs("fp.c5", 0, 0, 0, 0, 0, 0, 0, 0);
    chk_cnts("fp");
    tick;

    // FP start coincides with a load-use hazard: load-use deferred past release.
    in.fpE = 1'b1; in.wrE = 4'd5; in.rwE = 1'b1; in.mrE = 1'b1; in.rtD = 4'd5;
    for (int c = 1; c <= 3; c++) begin
      #1 chk_outs($sformatf("fplu.c%0d", c), 0, 0, 1, 1, 0, 0, 1, (c > 1));
      tick;
    end
    #1 chk_outs("fplu.c4", 0, 0, 0, 0, 0, 0, 0, 1);
    tick;
    in.fpE = 1'b0;
    #1 chk_outs("fplu.c5", 0, 0, 1, 0, 0, 1, 0, 0);
    tick;
    in = '0;
    chk_cnts("fplu");

    // Asynchronous reset mid FP_BUSY.
    in.fpE = 1'b1; in.rsE = 4'd3; in.wrM = 4'd3; in.rwM = 1'b1;
    tick;
    #2 rst = 1'b1;
    #1 chk_outs("arst", 0, 0, 0, 0, 0, 0, 0, 0);
    exp_sc = 0; exp_fc = 0;
    chk_cnts("arst");
    tick;
    in = '0;
    #2 rst = 1'b0;
    #1 chk_outs("arst.after", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk_cnts("arst.after");

    // Narrow-counter saturation and FP_LAT=2 on dut2.
    in2.wrE = 4'd5; in2.rwE = 1'b1; in2.mrE = 1'b1; in2.rtD = 4'd5;
    for (int c = 0; c < 5; c++) begin
      #1 chk($sformatf("sat.stall%0d", c), stPC2, 1);
      tick;
    end
    in2 = '0;
    #1 chk("sat.stall_cnt", scnt2, 3);
    in2.br = 1'b1;
    repeat (5) tick;
    in2 = '0;
    #1 chk("sat.flush_cnt", fcnt2, 3);
    chk("sat.stall_hold", scnt2, 3);
    in2.fpE = 1'b1;
    #1 chk("lat2.c1.stall", stPC2, 1);
    tick;
    #1 chk("lat2.c2.stall", stPC2, 0);
    chk("lat2.c2.busy", busy2, 1);
    in2.fpE = 1'b0;
    tick;
    #1 chk("lat2.c3.busy", busy2, 0);
    chk("lat2.stall_cnt", scnt2, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
